// File: rtl/opponent_state_rx.sv
// opponent_state_rx: parses the opponent game-state frame from the RMII dibit stream and commits it atomically.
// Optional destination-MAC filtering is enabled with `define OPP_RX_ADDR_FILTER_EN.
module opponent_state_rx #(
   parameter logic [15:0] ETHERTYPE = 16'h88B5,
   parameter logic [47:0] MY_MAC    = 48'h02_00_00_00_00_02,
   parameter logic [10:0] MAX_COORD = 11'd511,
   parameter logic [10:0] RESET_X   = 11'd319,
   parameter logic [10:0] RESET_Y   = 11'd319,
   parameter logic [8:0]  RESET_DIR = 9'd270
) (
   input  logic        clk_in,
   input  logic        rstn_in,
   input  logic        axiiv,
   input  logic [1:0]  axiid,
   output logic [10:0] opponent_x,
   output logic [10:0] opponent_y,
   output logic [8:0]  opponent_dir,
   output logic [1:0]  opponent_stat,
   output logic        update_out,
   output logic        err_out,
   output logic [7:0]  frame_cnt
);
   typedef enum logic [2:0] {GAP, IDLE, HDR, PAYLOAD, TAIL} state_t;
   state_t state, state_n;
   logic [6:0]  cnt;
   logic [5:0]  byte_sr;
   logic [39:0] sh;
   logic [7:0]  byte_w;
   logic        et_bad, addr_bad, rx, trunc, done, ok;
   assign byte_w = {axiid, byte_sr};
   assign rx     = axiiv && (state == HDR || state == PAYLOAD);
   assign trunc  = !axiiv && (state == HDR || state == PAYLOAD);
   assign done   = !axiiv && state == TAIL;
   assign ok     = !et_bad && !addr_bad && sh[39:29] <= MAX_COORD &&
                   sh[28:18] <= MAX_COORD && sh[17:9] <= 9'd359;
`ifdef OPP_RX_ADDR_FILTER_EN
   always_ff @(posedge clk_in or negedge rstn_in)
      if (!rstn_in) addr_bad <= 1'b0;
      else if (rx && cnt == 7'd23)
         addr_bad <= !({sh, byte_w} == MY_MAC || {sh, byte_w} == 48'hFFFF_FFFF_FFFF);
`else
   logic unused_mac;
   assign unused_mac = ^MY_MAC;
   assign addr_bad   = 1'b0;
`endif
   always_ff @(posedge clk_in or negedge rstn_in)
      if (!rstn_in) state <= GAP;
      else state <= state_n;
   always_comb begin
      state_n = state;
      case (state)
         GAP:     state_n = axiiv ? GAP : IDLE;
         IDLE:    state_n = axiiv ? HDR : IDLE;
         HDR:     state_n = !axiiv ? IDLE : (cnt == 7'd55 ? PAYLOAD : HDR);
         PAYLOAD: state_n = !axiiv ? IDLE : (cnt == 7'd75 ? TAIL : PAYLOAD);
         TAIL:    state_n = axiiv ? TAIL : IDLE;
         default: state_n = GAP;
      endcase
   end
   // cnt is the absolute dibit index; it freezes in TAIL so padding length is irrelevant
   always_ff @(posedge clk_in or negedge rstn_in)
      if (!rstn_in) begin
         cnt     <= '0;
         byte_sr <= '0;
         sh      <= '0;
         et_bad  <= 1'b0;
      end else begin
         if (state_n == IDLE) cnt <= '0;
         else if (axiiv && (state == IDLE || rx)) cnt <= cnt + 7'd1;
         if (axiiv && (state == IDLE || rx)) byte_sr <= {axiid, byte_sr[5:2]};
         if (rx && cnt[1:0] == 2'd3) sh <= {sh[31:0], byte_w};
         if (rx && cnt == 7'd55) et_bad <= {sh[7:0], byte_w} != ETHERTYPE;
      end
   always_ff @(posedge clk_in or negedge rstn_in)
      if (!rstn_in) begin
         opponent_x    <= RESET_X;
         opponent_y    <= RESET_Y;
         opponent_dir  <= RESET_DIR;
         opponent_stat <= 2'd0;
         update_out    <= 1'b0;
         err_out       <= 1'b0;
         frame_cnt     <= 8'd0;
      end else begin
         update_out <= done && ok;
         err_out    <= trunc || (done && !ok);
         if (done && ok) begin
            opponent_x    <= sh[39:29];
            opponent_y    <= sh[28:18];
            opponent_dir  <= sh[17:9];
            opponent_stat <= sh[8:7];
            frame_cnt     <= frame_cnt + 8'd1;
         end
      end
endmodule

// File: tb/tb_opponent_state_rx.sv
// tb_opponent_state_rx: scoreboard bench; expected commit/reject results are queued per frame and popped on each pulse.
module tb_opponent_state_rx;
   logic        clk_in = 1'b0, rstn_in = 1'b0, axiiv = 1'b0;
   logic [1:0]  axiid = 2'd0;
   logic [10:0] opponent_x, opponent_y;
   logic [8:0]  opponent_dir;
   logic [1:0]  opponent_stat;
   logic        update_out, err_out;
   logic [7:0]  frame_cnt;
   int          errors = 0, checks = 0;
   typedef struct {logic upd; logic [10:0] x, y; logic [8:0] dir; logic [1:0] stat; logic [7:0] cnt;} exp_t;
   exp_t        q[$];
   logic [7:0]  frm [0:22];
   logic [10:0] mx = 11'd319, my = 11'd319;
   logic [8:0]  mdir = 9'd270;
   logic [1:0]  mstat = 2'd0;
   logic [7:0]  mcnt = 8'd0;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] ME = 48'h02_00_00_00_00_02;

   opponent_state_rx dut (
      .clk_in(clk_in), .rstn_in(rstn_in), .axiiv(axiiv), .axiid(axiid),
      .opponent_x(opponent_x), .opponent_y(opponent_y), .opponent_dir(opponent_dir),
      .opponent_stat(opponent_stat), .update_out(update_out), .err_out(err_out),
      .frame_cnt(frame_cnt)
   );

   always #10 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string tag, input exp_t e);
      check({tag, "_x"}, 32'(opponent_x), 32'(e.x));
      check({tag, "_y"}, 32'(opponent_y), 32'(e.y));
      check({tag, "_dir"}, 32'(opponent_dir), 32'(e.dir));
      check({tag, "_stat"}, 32'(opponent_stat), 32'(e.stat));
      check({tag, "_cnt"}, 32'(frame_cnt), 32'(e.cnt));
   endtask

   always @(negedge clk_in)
      if (rstn_in && (update_out || err_out)) begin
         if (q.size() == 0) check("spurious_pulse", {30'd0, update_out, err_out}, 32'd0);
         else begin
            exp_t e;
            e = q.pop_front();
            check("pulse_kind", {30'd0, update_out, err_out}, e.upd ? 32'd2 : 32'd1);
            check_outs("sb", e);
         end
      end

   // nd = dibits actually sent (92 = full frame with FCS); rst_at >= 0 pulses reset at that dibit
   task automatic send(input logic [47:0] dst, input logic [15:0] et, input logic [10:0] x,
                       input logic [10:0] y, input logic [8:0] dir, input logic [1:0] stat,
                       input int nd, input int gap, input int rst_at);
      logic [39:0] p;
      logic        ok;
      exp_t        e;
      p = {x, y, dir, stat, 7'h55};
      for (int k = 0; k < 6; k++) frm[k] = dst[47-8*k -: 8];
      for (int k = 0; k < 6; k++) frm[6+k] = 8'h10 + 8'(k);
      frm[12] = et[15:8];
      frm[13] = et[7:0];
      for (int k = 0; k < 5; k++) frm[14+k] = p[39-8*k -: 8];
      for (int k = 19; k < 23; k++) frm[k] = 8'($urandom);
      ok = et == 16'h88B5 && x <= 11'd511 && y <= 11'd511 && dir <= 9'd359 && nd >= 76;
`ifdef OPP_RX_ADDR_FILTER_EN
      ok = ok && (dst == ME || dst == BCAST);
`endif
      if (rst_at < 0) begin
         if (ok) begin
            mx = x; my = y; mdir = dir; mstat = stat; mcnt = mcnt + 8'd1;
         end
         e = '{ok, mx, my, mdir, mstat, mcnt};
         q.push_back(e);
      end
      for (int i = 0; i < nd; i++) begin
         axiiv = 1'b1;
         axiid = frm[i/4][2*(i%4) +: 2];
         if (i == rst_at) begin
            rstn_in = 1'b0;
            #1;
            mx = 11'd319; my = 11'd319; mdir = 9'd270; mstat = 2'd0; mcnt = 8'd0;
            e = '{1'b0, mx, my, mdir, mstat, mcnt};
            check_outs("async_rst", e);
         end
         if (i == rst_at + 3) rstn_in = 1'b1;
         @(posedge clk_in);
         #1;
      end
      axiiv = 1'b0;
      axiid = 2'd0;
      @(posedge clk_in);
      #1;
      check(rst_at < 0 ? "latency" : "gap_ignore", 32'(update_out | err_out), rst_at < 0 ? 32'd1 : 32'd0);
      for (int i = 1; i < gap; i++) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   initial begin
      exp_t e0;
      repeat (3) @(posedge clk_in);
      #1 rstn_in = 1'b1;
      @(negedge clk_in);
      e0 = '{1'b0, 11'd319, 11'd319, 9'd270, 2'd0, 8'd0};
      check_outs("reset", e0);
      check("reset_pulses", {30'd0, update_out, err_out}, 32'd0);
      @(posedge clk_in);
      #1;
      send(ME, 16'h88B5, 11'd100, 11'd200, 9'd90, 2'd1, 92, 3, -1);
      send(ME, 16'h0800, 11'd7, 11'd7, 9'd7, 2'd2, 92, 3, -1);
      send(ME, 16'h88B5, 11'd7, 11'd7, 9'd360, 2'd2, 92, 3, -1);
      send(ME, 16'h88B5, 11'd600, 11'd7, 9'd7, 2'd2, 92, 3, -1);
      send(ME, 16'h88B5, 11'd7, 11'd512, 9'd7, 2'd2, 92, 3, -1);
      send(BCAST, 16'h88B5, 11'd511, 11'd511, 9'd359, 2'd3, 92, 3, -1);
      send(ME, 16'h88B5, 11'd1, 11'd2, 9'd3, 2'd0, 66, 1, -1);
      send(ME, 16'h88B5, 11'd5, 11'd6, 9'd0, 2'd2, 92, 3, -1);
      send(ME, 16'h88B5, 11'd9, 11'd9, 9'd9, 2'd1, 20, 2, -1);
      send(ME, 16'h88B5, 11'd0, 11'd0, 9'd0, 2'd0, 76, 1, -1);
      send(ME, 16'h88B5, 11'd33, 11'd44, 9'd180, 2'd1, 92, 1, -1);
      send(ME, 16'h88B5, 11'd77, 11'd88, 9'd45, 2'd2, 92, 3, 30);
      send(ME, 16'h88B5, 11'd12, 11'd34, 9'd56, 2'd3, 92, 1, -1);
      send(ME, 16'h88B5, 11'd13, 11'd35, 9'd57, 2'd1, 92, 3, -1);
`ifdef OPP_RX_ADDR_FILTER_EN
      send(48'h02_00_00_00_00_03, 16'h88B5, 11'd1, 11'd1, 9'd1, 2'd1, 92, 3, -1);
      send(BCAST, 16'h88B5, 11'd2, 11'd2, 9'd2, 2'd2, 92, 3, -1);
      send(ME, 16'h88B5, 11'd3, 11'd3, 9'd3, 2'd3, 92, 3, -1);
`endif
      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk_in);
      check("drain", q.size(), 32'd0);
      e0 = '{1'b0, mx, my, mdir, mstat, mcnt};
      check_outs("final", e0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/opponent_state_rx.md
Name: opponent_state_rx

Overview:
- Receive-side counterpart of the game-state transmitter.
- Consumes the dibit stream from the RMII receiver on the 50 MHz eth_refclk domain. This stream has preamble and SFD already stripped and starts at the first destination-MAC dibit.
- Parses the opponent's game-state frame, validates it, and atomically updates the registered opponent position, direction and status for track_view and racer_view.

Parameters:
- ETHERTYPE, 16'h88B5, required EtherType.
- MY_MAC, 48'h02_00_00_00_00_02, local station address; used only with the optional feature.
- MAX_COORD, 11'd511, largest legal x/y.
- RESET_X, 11'd319, opponent_x value at reset.
- RESET_Y, 11'd319, opponent_y value at reset.
- RESET_DIR, 9'd270, opponent_dir value at reset.

Ports:
- clk_in  input  1  eth_refclk, 50 MHz
- rstn_in  input  1  asynchronous active-low reset
- axiiv  input  1  receiver data valid; high for the whole frame
- axiid  input  2  receiver dibit
- opponent_x  output  11  last accepted x
- opponent_y  output  11  last accepted y
- opponent_dir  output  9  last accepted direction, degrees 0..359
- opponent_stat  output  2  last accepted game status
- update_out  output  1  one-cycle pulse when new values are applied
- err_out  output  1  one-cycle pulse when a frame is rejected
- frame_cnt  output  8  accepted-frame count, wraps 255->0

Behaviour:
- Reset (async, rstn_in=0):
  - opponent_x=RESET_X, opponent_y=RESET_Y, opponent_dir=RESET_DIR, opponent_stat=0.
  - update_out=0, err_out=0, frame_cnt=0.
  - FSM goes to GAP; all shadow registers and counters are cleared.
- Byte assembly:
  - Four consecutive valid dibits form one byte = {d3,d2,d1,d0}; d0 is the first dibit received (LSB first).
  - Bytes are ordered big-endian within each field.
- Frame layout in bytes:
  - 0-5: destination MAC
  - 6-11: source MAC
  - 12-13: EtherType
  - 14-18: payload, 5 bytes forming P[39:0]
  - 19 onward (padding, FCS): ignored
- Payload fields: P[39:29]=x, P[28:18]=y, P[17:9]=dir, P[8:7]=stat, P[6:0] reserved and ignored.
- FSM states:
  - GAP: wait for axiiv=0, then go to IDLE. This is the exit-from-reset state, so a frame already in progress when reset releases is never parsed.
  - IDLE: on axiiv=1, take the first dibit and go to HDR.
  - HDR: count 56 dibits. The EtherType mismatch flag is registered on the last EtherType dibit. Then go to PAYLOAD.
  - PAYLOAD: shift 20 dibits into the shadow register, then go to TAIL.
  - TAIL: ignore dibits. On axiiv falling, go to IDLE and run the commit decision (see Commit).
  - axiiv falling in HDR or PAYLOAD (truncated frame): err_out pulse, no update, go to IDLE.
- Dibit counter: 7-bit, clears on every IDLE entry.
- Commit: on the cycle axiiv is sampled 0 in TAIL, the frame is accepted if all of the following hold:
  - EtherType == ETHERTYPE
  - x <= MAX_COORD and y <= MAX_COORD
  - dir <= 359
  - (optional) address check passes
- Commit latency:
  - Accepted frame: outputs take the shadow values at the next clock edge. update_out pulses for that same cycle and frame_cnt increments.
  - Rejected frame: outputs hold and err_out pulses instead.
- Outputs change only at commit; there are never partial updates.
- Frames arriving back-to-back with a single idle cycle between them must both be processed.
- Reset asserted mid-frame: outputs return to their reset values immediately and the frame is discarded.

Optional Feature:
- Macro: OPP_RX_ADDR_FILTER_EN.
- Defined: the destination MAC must equal MY_MAC or ff:ff:ff:ff:ff:ff, otherwise the frame is rejected (err_out).
- Undefined: the destination MAC is ignored and the address-compare logic is absent.

Test Plan:
- Reset check: deassert rstn_in with axiiv idle -> opponent_x=319, opponent_y=319, opponent_dir=270, opponent_stat=0, frame_cnt=0, no pulses.
- Valid frame: EtherType 88B5, x=100, y=200, dir=90, stat=1, plus 4 FCS bytes -> one cycle after axiiv falls, outputs 100/200/90/1, update_out=1 for exactly one cycle, frame_cnt=1.
- Wrong EtherType (0800), or dir=360, or x=600 -> err_out pulse; outputs unchanged; frame_cnt unchanged.
- Truncation: axiiv drops after 10 payload dibits -> err_out pulse, no update. A following valid frame with x=5 after 1 idle cycle -> opponent_x=5.
- Reset and back-to-back:
  - Release rstn_in while axiiv=1 mid-frame -> that frame is ignored (GAP).
  - Two back-to-back valid frames -> two update_out pulses, frame_cnt=2.
- With OPP_RX_ADDR_FILTER_EN: destination 02:00:00:00:00:03 -> err_out. Destination broadcast or MY_MAC -> update_out.
